// File: rtl/traffic_led_monitor.sv
// traffic_led_monitor
//   Passive watchdog on the far end of the traffic controller's LED bus.
//   Decodes led[6:0] into a phase, then checks transition legality, minimum
//   and maximum dwell, and pedestrian-request service latency. Errors are
//   sticky until clear_err; a phase-change counter is exported.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high
//   led[7:0]     controller LED bus (bit 7 unused)
//   ped_req      pedestrian request level; rising edge starts the latency timer
//   clear_err    one-cycle pulse, clears the sticky error flags
//   phase[2:0]   0 MG, 1 MY, 2 AR, 3 SG, 4 SY, 5 WALK, 7 NONE
//   phase_valid  locked to a legal phase
//   phase_count  legal phase changes seen (wraps)
//   err_*        sticky error flags, err_any is their OR
//
// Monitor states
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_INIT  | unlocked; waiting for the first legal pattern (0x00 ignored)
//   ST_TRACK | locked to a phase; dwell, transition and pattern checks live

module traffic_led_monitor #(
  parameter bit          ACTIVE_LOW  = 1'b0,
  parameter int unsigned MIN_DWELL   = 4,
  parameter int unsigned MIN_YELLOW  = 8,
  parameter int unsigned MAX_PHASE   = 1000,
  parameter int unsigned PED_TIMEOUT = 2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  led,
  input  logic        ped_req,
  input  logic        clear_err,
  output logic [2:0]  phase,
  output logic        phase_valid,
  output logic [15:0] phase_count,
  output logic        err_illegal,
  output logic        err_seq,
  output logic        err_timing,
  output logic        err_stuck,
  output logic        err_ped,
  output logic        err_any
);

  typedef enum logic [2:0] {
    PH_MG   = 3'd0,
    PH_MY   = 3'd1,
    PH_AR   = 3'd2,
    PH_SG   = 3'd3,
    PH_SY   = 3'd4,
    PH_WALK = 3'd5,
    PH_NONE = 3'd7
  } phase_t;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_TRACK = 1'b1
  } mon_state_t;

  localparam logic [6:0] PAT_MG   = 7'h21;
  localparam logic [6:0] PAT_MY   = 7'h22;
  localparam logic [6:0] PAT_AR   = 7'h24;
  localparam logic [6:0] PAT_SG   = 7'h0C;
  localparam logic [6:0] PAT_SY   = 7'h14;
  localparam logic [6:0] PAT_WALK = 7'h64;

  localparam logic [31:0] MIN_DWELL_C   = 32'(MIN_DWELL);
  localparam logic [31:0] MIN_YELLOW_C  = 32'(MIN_YELLOW);
  localparam logic [31:0] MAX_PHASE_C   = 32'(MAX_PHASE);
  localparam logic [31:0] PED_TIMEOUT_C = 32'(PED_TIMEOUT);

  // error vector bit positions
  localparam int E_ILL = 0;
  localparam int E_SEQ = 1;
  localparam int E_TIM = 2;
  localparam int E_STK = 3;
  localparam int E_PED = 4;

  logic        unused_led7;
  logic [6:0]  led_fix;
  logic [6:0]  led_q;

  mon_state_t  state_q, state_d;
  phase_t      phase_q, phase_d;
  phase_t      last_yellow_q, last_yellow_d;
  logic        valid_q, valid_d;
  logic [15:0] count_q, count_d;
  logic [31:0] dwell_q, dwell_d;
  logic [4:0]  err_q, err_d, err_set;

  logic        ped_req_q;
  logic        ped_rise;
  logic        ped_pend_q, ped_pend_d;
  logic [31:0] ped_left_q, ped_left_d;

  phase_t      dec_phase;
  logic        dec_legal;
  logic        entered_walk;

  assign unused_led7 = led[7];
  assign led_fix     = ACTIVE_LOW ? ~led[6:0] : led[6:0];
  assign ped_rise    = ped_req & ~ped_req_q;

  function automatic logic trans_ok(input phase_t from_ph, input phase_t to_ph,
                                    input phase_t last_y);
    logic ok;
    ok = 1'b0;
    case (from_ph)
      PH_MG:   ok = (to_ph == PH_MY);
      PH_MY:   ok = (to_ph == PH_AR);
      PH_SG:   ok = (to_ph == PH_SY);
      PH_SY:   ok = (to_ph == PH_AR);
      PH_WALK: ok = (to_ph == PH_AR);
      // all-red alternates between the two roads based on who yielded last
      PH_AR:   ok = (to_ph == PH_WALK) ||
                    ((to_ph == PH_SG) && (last_y == PH_MY)) ||
                    ((to_ph == PH_MG) && (last_y == PH_SY));
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  always_comb begin
    dec_phase = PH_NONE;
    dec_legal = 1'b1;
    case (led_q)
      PAT_MG:   dec_phase = PH_MG;
      PAT_MY:   dec_phase = PH_MY;
      PAT_AR:   dec_phase = PH_AR;
      PAT_SG:   dec_phase = PH_SG;
      PAT_SY:   dec_phase = PH_SY;
      PAT_WALK: dec_phase = PH_WALK;
      default:  dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    last_yellow_d = last_yellow_q;
    valid_d       = valid_q;
    count_d       = count_q;
    dwell_d       = dwell_q;
    err_set       = '0;
    entered_walk  = 1'b0;

    case (state_q)
      ST_INIT: begin
        if (dec_legal) begin
          phase_d      = dec_phase;
          valid_d      = 1'b1;
          dwell_d      = 32'd1;
          state_d      = ST_TRACK;
          entered_walk = (dec_phase == PH_WALK);
          if ((dec_phase == PH_MY) || (dec_phase == PH_SY)) begin
            last_yellow_d = dec_phase;
          end
        end else if (led_q != 7'h00) begin
          err_set[E_ILL] = 1'b1;
        end
      end

      ST_TRACK: begin
        if (!dec_legal) begin
          err_set[E_ILL] = 1'b1;
          phase_d        = PH_NONE;
          valid_d        = 1'b0;
          dwell_d        = '0;
          state_d        = ST_INIT;
        end else if (dec_phase == phase_q) begin
          if (dwell_q != '1) begin
            dwell_d = dwell_q + 32'd1;
            // equality fires once per phase since dwell only ever climbs
            if ((dwell_q + 32'd1) == MAX_PHASE_C) begin
              err_set[E_STK] = 1'b1;
            end
          end
        end else begin
          if (dwell_q < MIN_DWELL_C) begin
            err_set[E_TIM] = 1'b1;
          end
          if (((phase_q == PH_MY) || (phase_q == PH_SY)) && (dwell_q < MIN_YELLOW_C)) begin
            err_set[E_TIM] = 1'b1;
          end
          if (!trans_ok(phase_q, dec_phase, last_yellow_q)) begin
            err_set[E_SEQ] = 1'b1;
          end
          phase_d      = dec_phase;
          dwell_d      = 32'd1;
          count_d      = count_q + 16'd1;
          entered_walk = (dec_phase == PH_WALK);
          if ((dec_phase == PH_MY) || (dec_phase == PH_SY)) begin
            last_yellow_d = dec_phase;
          end
        end
      end

      default: begin
        state_d = ST_INIT;
        phase_d = PH_NONE;
        valid_d = 1'b0;
      end
    endcase
  end

  // Pedestrian latency: down-counter loaded on request, error on terminal count.
  always_comb begin
    ped_pend_d = ped_pend_q;
    ped_left_d = ped_left_q;
    if (ped_pend_q) begin
      if (entered_walk) begin
        ped_pend_d = 1'b0;
      end else if (ped_left_q <= 32'd1) begin
        ped_pend_d = 1'b0;
      end else begin
        ped_left_d = ped_left_q - 32'd1;
      end
    end else if (ped_rise && (phase_q != PH_WALK) && !entered_walk) begin
      // a press on the very edge WALK starts is already being served
      ped_pend_d = 1'b1;
      ped_left_d = PED_TIMEOUT_C;
    end
  end

  always_comb begin
    err_d = (err_q & ~{5{clear_err}}) | err_set;
    if (ped_pend_q && !entered_walk && (ped_left_q <= 32'd1)) begin
      err_d[E_PED] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q         <= '0;
      state_q       <= ST_INIT;
      phase_q       <= PH_NONE;
      last_yellow_q <= PH_SY;
      valid_q       <= 1'b0;
      count_q       <= '0;
      dwell_q       <= '0;
      err_q         <= '0;
      ped_req_q     <= 1'b0;
      ped_pend_q    <= 1'b0;
      ped_left_q    <= '0;
    end else begin
      led_q         <= led_fix;
      state_q       <= state_d;
      phase_q       <= phase_d;
      last_yellow_q <= last_yellow_d;
      valid_q       <= valid_d;
      count_q       <= count_d;
      dwell_q       <= dwell_d;
      err_q         <= err_d;
      ped_req_q     <= ped_req;
      ped_pend_q    <= ped_pend_d;
      ped_left_q    <= ped_left_d;
    end
  end

  assign phase       = phase_q;
  assign phase_valid = valid_q;
  assign phase_count = count_q;
  assign err_illegal = err_q[E_ILL];
  assign err_seq     = err_q[E_SEQ];
  assign err_timing  = err_q[E_TIM];
  assign err_stuck   = err_q[E_STK];
  assign err_ped     = err_q[E_PED];
  assign err_any     = |err_q;

endmodule

// File: tb/tb_traffic_led_monitor.sv
// Bench for traffic_led_monitor: a table of {hold pattern, expected outputs}
// records followed by hand-written pedestrian-latency sequences.

module tb_traffic_led_monitor;

  localparam logic [7:0] MG   = 8'h21;
  localparam logic [7:0] MY   = 8'h22;
  localparam logic [7:0] AR   = 8'h24;
  localparam logic [7:0] SG   = 8'h0C;
  localparam logic [7:0] SY   = 8'h14;
  localparam logic [7:0] WALK = 8'h64;

  logic        clk;
  logic        reset;
  logic [7:0]  led;
  logic        ped_req;
  logic        clear_err;
  logic [2:0]  phase;
  logic        phase_valid;
  logic [15:0] phase_count;
  logic        err_illegal, err_seq, err_timing, err_stuck, err_ped, err_any;

  int n_checks = 0;
  int n_errors = 0;

  traffic_led_monitor dut (
    .clk         (clk),
    .reset       (reset),
    .led         (led),
    .ped_req     (ped_req),
    .clear_err   (clear_err),
    .phase       (phase),
    .phase_valid (phase_valid),
    .phase_count (phase_count),
    .err_illegal (err_illegal),
    .err_seq     (err_seq),
    .err_timing  (err_timing),
    .err_stuck   (err_stuck),
    .err_ped     (err_ped),
    .err_any     (err_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {ped, stuck, timing, seq, illegal}
  function automatic logic [4:0] errs();
    return {err_ped, err_stuck, err_timing, err_seq, err_illegal};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [7:0]  led;
    logic        clr;
    int          n;
    logic [2:0]  ph;
    logic        v;
    logic [15:0] cnt;
    logic [4:0]  err;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [7:0] l, input logic c, input int n,
                     input logic [2:0] ph, input logic v, input logic [15:0] cnt,
                     input logic [4:0] e);
    vec_t x;
    x.rst = r; x.led = l; x.clr = c; x.n = n;
    x.ph = ph; x.v = v; x.cnt = cnt; x.err = e;
    tbl.push_back(x);
  endtask

  // one clock with the given inputs, returning at the next falling edge
  task automatic step(input logic [7:0] l, input logic c, input logic p);
    led = l; clear_err = c; ped_req = p;
    @(negedge clk);
    clear_err = 1'b0;
    ped_req   = 1'b0;
  endtask

  // legal 70-cycle loop starting at MG, never touching WALK
  function automatic logic [7:0] seq_led(input int t);
    int m;
    m = t % 70;
    if (m < 20) return MG;
    if (m < 30) return MY;
    if (m < 35) return AR;
    if (m < 55) return SG;
    if (m < 65) return SY;
    return AR;
  endfunction

  // as seq_led but with all-red stretched and WALK entered at cycle 500
  function automatic logic [7:0] ped2_led(input int t);
    if (t < 490) return seq_led(t);
    if (t < 500) return AR;
    if (t < 520) return WALK;
    if (t < 525) return AR;
    return seq_led(t - 525);
  endfunction

  initial begin
    reset = 1'b1; led = 8'h00; ped_req = 1'b0; clear_err = 1'b0;

    //   rst led   clr n     ph v cnt err
    add(1, 8'h00, 0, 3,    7, 0, 0,  5'b00000);
    add(0, 8'h00, 0, 2,    7, 0, 0,  5'b00000);
    add(0, MG,    0, 20,   0, 1, 0,  5'b00000);
    add(0, MY,    0, 10,   1, 1, 1,  5'b00000);
    add(0, AR,    0, 5,    2, 1, 2,  5'b00000);
    add(0, SG,    0, 20,   3, 1, 3,  5'b00000);
    add(0, SY,    0, 10,   4, 1, 4,  5'b00000);
    add(0, AR,    0, 5,    2, 1, 5,  5'b00000);
    add(0, MG,    0, 20,   0, 1, 6,  5'b00000);
    // short yellow
    add(0, MY,    0, 5,    1, 1, 7,  5'b00000);
    add(0, AR,    0, 2,    2, 1, 8,  5'b00100);
    add(0, AR,    0, 3,    2, 1, 8,  5'b00100);
    add(0, AR,    1, 1,    2, 1, 8,  5'b00000);
    // MG straight to SG
    add(0, SG,    0, 10,   3, 1, 9,  5'b00000);
    add(0, SY,    0, 10,   4, 1, 10, 5'b00000);
    add(0, AR,    0, 5,    2, 1, 11, 5'b00000);
    add(0, MG,    0, 10,   0, 1, 12, 5'b00000);
    add(0, SG,    0, 5,    3, 1, 13, 5'b00010);
    add(0, SG,    1, 1,    3, 1, 13, 5'b00000);
    // one-cycle glitch mid-MG, then relock
    add(0, SY,    0, 10,   4, 1, 14, 5'b00000);
    add(0, AR,    0, 5,    2, 1, 15, 5'b00000);
    add(0, MG,    0, 10,   0, 1, 16, 5'b00000);
    add(0, 8'h3F, 0, 1,    0, 1, 16, 5'b00000);
    add(0, MG,    0, 1,    7, 0, 16, 5'b00001);
    add(0, MG,    0, 1,    0, 1, 16, 5'b00001);
    add(0, MG,    0, 8,    0, 1, 16, 5'b00001);
    add(0, MG,    1, 1,    0, 1, 16, 5'b00000);
    // stuck boundary: dwell 999 then 1000
    add(0, MY,    0, 10,   1, 1, 17, 5'b00000);
    add(0, AR,    0, 5,    2, 1, 18, 5'b00000);
    add(0, SG,    0, 10,   3, 1, 19, 5'b00000);
    add(0, SY,    0, 10,   4, 1, 20, 5'b00000);
    add(0, AR,    0, 5,    2, 1, 21, 5'b00000);
    add(0, MG,    0, 1000, 0, 1, 22, 5'b00000);
    add(0, MG,    0, 1,    0, 1, 22, 5'b01000);
    add(0, MG,    1, 1,    0, 1, 22, 5'b00000);
    // reset mid-SG
    add(0, MY,    0, 10,   1, 1, 23, 5'b00000);
    add(0, AR,    0, 5,    2, 1, 24, 5'b00000);
    add(0, SG,    0, 10,   3, 1, 25, 5'b00000);
    add(1, SG,    0, 1,    7, 0, 0,  5'b00000);
    add(0, SG,    0, 10,   3, 1, 0,  5'b00000);
    add(0, SY,    0, 10,   4, 1, 1,  5'b00000);
    add(0, AR,    0, 5,    2, 1, 2,  5'b00000);
    add(0, MG,    0, 5,    0, 1, 3,  5'b00000);

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst; led = tbl[i].led; clear_err = tbl[i].clr;
      repeat (tbl[i].n) @(negedge clk);
      clear_err = 1'b0;
      chk($sformatf("v%0d_phase", i), int'(phase), int'(tbl[i].ph));
      chk($sformatf("v%0d_valid", i), int'(phase_valid), int'(tbl[i].v));
      chk($sformatf("v%0d_count", i), int'(phase_count), int'(tbl[i].cnt));
      chk($sformatf("v%0d_errs", i), int'(errs()), int'(tbl[i].err));
      chk($sformatf("v%0d_err_any", i), int'(err_any), int'(|tbl[i].err));
    end
    reset = 1'b0;

    // request never served: flag exactly 2000 edges after the press edge
    step(seq_led(0), 1'b0, 1'b1);
    for (int k = 1; k < 2000; k++) step(seq_led(k), 1'b0, 1'b0);
    chk("ped_before_timeout", int'(errs()), 0);
    step(seq_led(2000), 1'b0, 1'b0);
    chk("ped_timeout", int'(errs()), 5'b10000);
    chk("ped_timeout_any", int'(err_any), 1);
    for (int k = 2001; k < 2030; k++) step(seq_led(k), (k == 2010), 1'b0);
    chk("ped_cleared", int'(errs()), 0);

    // request served by WALK at cycle 500
    step(ped2_led(0), 1'b0, 1'b1);
    for (int t = 1; t <= 2100; t++) begin
      step(ped2_led(t), 1'b0, 1'b0);
      if (t == 510) chk("walk_phase", int'(phase), 5);
      if (t == 2000) chk("ped_served_at_2000", int'(errs()), 0);
    end
    chk("ped_served_end", int'(errs()), 0);
    chk("ped_served_any", int'(err_any), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
